// File: rtl/div_arbiter.sv
// div_arbiter: round-robin share of one int_divider among N requesters; DIV_ARB_PAIR_EN adds complement-pair priority.
// Latency: issue is combinational (0 cycles); result is routed to the owner in the cycle div_valid_out rises.
// Backpressure: a stalled owner holds the divider result via div_ready_in; no other requester issues meanwhile.
module div_arbiter #(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [2*N-1:0] req_op,
  input  logic [W*N-1:0] req_a,
  input  logic [W*N-1:0] req_b,
  output logic [N-1:0]   resp_valid,
  input  logic [N-1:0]   resp_ready,
  output logic [W-1:0]   resp_y,
  output logic           div_valid_in,
  input  logic           div_ready_out,
  output logic [1:0]     div_op,
  output logic [W-1:0]   div_a,
  output logic [W-1:0]   div_b,
  input  logic           div_valid_out,
  output logic           div_ready_in,
  input  logic [W-1:0]   div_y
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IW-1:0] grant;
  logic          grant_found;
  logic          pair_hit;
  logic          fire;
  logic          done;

`ifdef DIV_ARB_PAIR_EN
  logic [1:0]   last_op;
  logic [W-1:0] last_a;
  logic [W-1:0] last_b;
  logic         first_idle;

  // The issued operands equal the completed op's operands once the response handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_idle <= 1'b0;
      last_op    <= '0;
      last_a     <= '0;
      last_b     <= '0;
    end else begin
      first_idle <= done;
      if (fire) begin
        last_op <= div_op;
        last_a  <= div_a;
        last_b  <= div_b;
      end
    end
  end

  assign pair_hit = first_idle && (state == IDLE) && req_valid[owner]
                 && (req_op[2*int'(owner) +: 2] == {~last_op[1], last_op[0]})
                 && (req_a[W*int'(owner) +: W] == last_a)
                 && (req_b[W*int'(owner) +: W] == last_b);
`else
  assign pair_hit = 1'b0;
`endif

  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!grant_found && req_valid[idx]) begin
        grant       = IW'(idx);
        grant_found = 1'b1;
      end
    end
    if (pair_hit) grant = owner;
  end

  always_comb begin
    int gi;
    gi           = int'(grant);
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    req_ready    = '0;
    resp_valid   = '0;
    div_valid_in = 1'b0;
    div_op       = '0;
    div_a        = '0;
    div_b        = '0;
    div_ready_in = 1'b1;
    fire         = 1'b0;
    done         = 1'b0;
    resp_y       = div_y;
    if (!reset) begin
      case (state)
        IDLE: begin
          div_valid_in = |req_valid;
          if (grant_found) begin
            div_op           = req_op[2*gi +: 2];
            div_a            = req_a[W*gi +: W];
            div_b            = req_b[W*gi +: W];
            req_ready[grant] = div_ready_out;
          end
          fire = div_valid_in && div_ready_out;
          if (fire) begin
            owner_nxt = grant;
            state_nxt = WAIT;
            if (pair_hit)
              rr_ptr_nxt = rr_ptr;
            else if (grant == IW'(N-1))
              rr_ptr_nxt = '0;
            else
              rr_ptr_nxt = grant + 1'b1;
          end
        end
        WAIT: begin
          resp_valid[owner] = div_valid_out;
          div_ready_in      = resp_ready[owner];
          done              = div_valid_out && resp_ready[owner];
          if (done) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: drives div_arbiter with a behavioural divider and checks routing, ordering and timing.
module tb_div_arbiter;
  localparam int N = 2;
  localparam int W = 32;
  localparam logic [1:0] UDIV = 2'd0, SDIV = 2'd1, UREM = 2'd2, SREM = 2'd3;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_a, req_b;
  logic [N-1:0]   resp_valid, resp_ready;
  logic [W-1:0]   resp_y;
  logic           div_valid_in, div_ready_out;
  logic [1:0]     div_op;
  logic [W-1:0]   div_a, div_b;
  logic           div_valid_out, div_ready_in;
  logic [W-1:0]   div_y;

  int errors;
  int checks;

  div_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
    .div_valid_in(div_valid_in), .div_ready_out(div_ready_out),
    .div_op(div_op), .div_a(div_a), .div_b(div_b),
    .div_valid_out(div_valid_out), .div_ready_in(div_ready_in), .div_y(div_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (op)
      UDIV: return (b == 0) ? 32'hFFFFFFFF : a / b;
      UREM: return (b == 0) ? a : a % b;
      SDIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (ovf) return a;
        return sa / sb;
      end
      default: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return sa % sb;
      end
    endcase
  endfunction

  // Divider stand-in: 4 cycles per op, 1 cycle when the complement of the previous op on equal operands.
  logic        dv_busy, dv_vout, dv_have;
  int          dv_cnt;
  logic [31:0] dv_res, dv_la, dv_lb;
  logic [1:0]  dv_lop;
  assign div_ready_out = !dv_busy;
  assign div_valid_out = dv_vout;
  assign div_y         = dv_res;

  always @(posedge clk) begin
    if (reset) begin
      dv_busy <= 1'b0;
      dv_vout <= 1'b0;
      dv_cnt  <= 0;
      dv_have <= 1'b0;
    end else if (!dv_busy) begin
      if (div_valid_in) begin
        dv_busy <= 1'b1;
        dv_res  <= ref_div(div_op, div_a, div_b);
        dv_cnt  <= (dv_have && div_op == (dv_lop ^ 2'b10) && div_a == dv_la && div_b == dv_lb) ? 1 : 4;
        dv_have <= 1'b1;
        dv_lop  <= div_op;
        dv_la   <= div_a;
        dv_lb   <= div_b;
      end
    end else if (!dv_vout) begin
      if (dv_cnt == 1) dv_vout <= 1'b1;
      dv_cnt <= dv_cnt - 1;
    end else if (div_ready_in) begin
      dv_vout <= 1'b0;
      dv_busy <= 1'b0;
    end
  end

  task automatic drive(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[2*k +: 2]  = op;
    req_a[32*k +: 32] = a;
    req_b[32*k +: 32] = b;
    req_valid[k]      = 1'b1;
  endtask

  task automatic do_issue(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
    drive(k, op, a, b);
    cyc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        cyc = n;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_resp(input int k, output int cyc, output logic [31:0] y, output logic other);
    cyc   = -1;
    y     = '0;
    other = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((resp_valid & ~(2'b01 << k)) != 0) other = 1'b1;
      if (resp_valid[k]) begin
        cyc = n;
        y   = resp_y;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_dut();
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = '1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 2'b11;
    req_a     = {32'd8, 32'd9};
    req_b     = {32'd2, 32'd3};
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    checks++; if (div_valid_in !== 1'b0) begin errors++; $display("FAIL reset_div_valid_in: got %b want 0", div_valid_in); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
    checks++; if (div_ready_in !== 1'b1) begin errors++; $display("FAIL reset_div_ready_in: got %b want 1", div_ready_in); end
    @(posedge clk); #1;
    req_valid = '0;
    reset     = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00 || div_valid_in !== 1'b0)
      begin errors++; $display("FAIL idle_no_req: req_ready=%b div_valid_in=%b want 00/0", req_ready, div_valid_in); end
    checks++; if (div_op !== 2'd0 || div_a !== 32'd0 || div_b !== 32'd0)
      begin errors++; $display("FAIL idle_zero_operands: op=%0d a=%0h b=%0h want 0", div_op, div_a, div_b); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int cyc; logic [31:0] y; logic other;
    drive(0, UDIV, 32'd100, 32'd7);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
    checks++; if (div_valid_in !== 1'b1 || div_op !== UDIV || div_a !== 32'd100 || div_b !== 32'd7)
      begin errors++; $display("FAIL single_issue: v=%b op=%0d a=%0d b=%0d want 1/0/100/7", div_valid_in, div_op, div_a, div_b); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_resp(0, cyc, y, other);
    checks++; if (cyc != 4) begin errors++; $display("FAIL single_latency: got %0d want 4", cyc); end
    checks++; if (y !== 32'd14) begin errors++; $display("FAIL single_result: got %0d want 14", y); end
    checks++; if (other !== 1'b0) begin errors++; $display("FAIL single_other_resp: got %b want 0", other); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL single_resp_drop: got %b want 00", resp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int cyc; logic [31:0] y; logic other;
    reset_dut();
    drive(0, UDIV, 32'd50, 32'd5);
    drive(1, UREM, 32'd50, 32'd7);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cont_first: got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_resp(0, cyc, y, other);
    checks++; if (y !== 32'd10) begin errors++; $display("FAIL cont_res0: got %0d want 10", y); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL cont_second: got %b want 10", req_ready); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_resp(1, cyc, y, other);
    checks++; if (y !== 32'd1 || other !== 1'b0)
      begin errors++; $display("FAIL cont_res1: got %0d other=%b want 1/0", y, other); end
    @(posedge clk); #1;
    drive(0, SDIV, 32'd21, 32'd4);
    drive(1, UDIV, 32'd21, 32'd4);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cont_wrap: got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_resp(0, cyc, y, other);
    @(posedge clk); #1;
    do_issue(1, UDIV, 32'd21, 32'd4, cyc);
    checks++; if (cyc != 0) begin errors++; $display("FAIL cont_loser_retry: waited %0d want 0", cyc); end
    wait_resp(1, cyc, y, other);
    checks++; if (y !== 32'd5) begin errors++; $display("FAIL cont_res_loser: got %0d want 5", y); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int cyc; logic [31:0] y; logic other; logic held_bad;
    resp_ready[1] = 1'b0;
    do_issue(1, SREM, 32'hFFFFFFF9, 32'd2, cyc);
    drive(0, UDIV, 32'd30, 32'd4);
    wait_resp(1, cyc, y, other);
    checks++; if (y !== 32'hFFFFFFFF) begin errors++; $display("FAIL bp_result: got %0h want ffffffff", y); end
    held_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (resp_valid !== 2'b10 || resp_y !== y || req_ready !== 2'b00) held_bad = 1'b1;
    end
    checks++; if (held_bad !== 1'b0) begin errors++; $display("FAIL bp_hold: got unstable/leak=%b want 0", held_bad); end
    @(posedge clk); #1;
    resp_ready[1] = 1'b1;
    @(negedge clk);
    checks++; if (div_ready_in !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", div_ready_in); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01 || resp_valid !== 2'b00)
      begin errors++; $display("FAIL bp_next_issue: req_ready=%b resp_valid=%b want 01/00", req_ready, resp_valid); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_resp(0, cyc, y, other);
    checks++; if (y !== 32'd7 || cyc != 4) begin errors++; $display("FAIL bp_res0: got %0d lat %0d want 7/4", y, cyc); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc; logic [31:0] y; logic other; logic leak;
    do_issue(0, UDIV, 32'd1000, 32'd3, cyc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 2'b00 || div_ready_in !== 1'b1 || div_valid_in !== 1'b0)
      begin errors++; $display("FAIL mid_reset_idle: rv=%b dri=%b dvi=%b want 00/1/0", resp_valid, div_ready_in, div_valid_in); end
    leak = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (resp_valid !== 2'b00) leak = 1'b1;
    end
    checks++; if (leak !== 1'b0) begin errors++; $display("FAIL mid_reset_discard: got %b want 0", leak); end
    @(posedge clk); #1;
    do_issue(0, UDIV, 32'd9, 32'd3, cyc);
    checks++; if (cyc != 0) begin errors++; $display("FAIL mid_reset_reissue: waited %0d want 0", cyc); end
    wait_resp(0, cyc, y, other);
    checks++; if (y !== 32'd3 || cyc != 4) begin errors++; $display("FAIL mid_reset_result: got %0d lat %0d want 3/4", y, cyc); end
    @(posedge clk); #1;
  endtask

  task automatic test_pair();
    int cyc; logic [31:0] y; logic other;
    logic [1:0] exp_rdy;
    do_issue(0, SDIV, 32'hFFFFFFEC, 32'd3, cyc);
    drive(0, SREM, 32'hFFFFFFEC, 32'd3);
    drive(1, UDIV, 32'd40, 32'd6);
    wait_resp(0, cyc, y, other);
    checks++; if (y !== 32'hFFFFFFFA) begin errors++; $display("FAIL pair_sdiv: got %0h want fffffffa", y); end
    @(posedge clk); #1;
    @(negedge clk);
`ifdef DIV_ARB_PAIR_EN
    exp_rdy = 2'b01;
`else
    exp_rdy = 2'b10;
`endif
    checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL pair_grant: got %b want %b", req_ready, exp_rdy); end
    @(posedge clk); #1;
`ifdef DIV_ARB_PAIR_EN
    req_valid[0] = 1'b0;
    wait_resp(0, cyc, y, other);
    checks++; if (y !== 32'hFFFFFFFE || cyc != 1) begin errors++; $display("FAIL pair_srem: got %0h lat %0d want fffffffe/1", y, cyc); end
    @(posedge clk); #1;
    do_issue(1, UDIV, 32'd40, 32'd6, cyc);
    wait_resp(1, cyc, y, other);
    checks++; if (y !== 32'd6) begin errors++; $display("FAIL pair_udiv: got %0d want 6", y); end
`else
    req_valid[1] = 1'b0;
    wait_resp(1, cyc, y, other);
    checks++; if (y !== 32'd6) begin errors++; $display("FAIL pair_udiv: got %0d want 6", y); end
    @(posedge clk); #1;
    do_issue(0, SREM, 32'hFFFFFFEC, 32'd3, cyc);
    wait_resp(0, cyc, y, other);
    checks++; if (y !== 32'hFFFFFFFE || cyc != 4) begin errors++; $display("FAIL pair_srem: got %0h lat %0d want fffffffe/4", y, cyc); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int cyc; logic [31:0] y; logic other;
    do_issue(0, UDIV, 32'd5, 32'd0, cyc);
    wait_resp(0, cyc, y, other);
    checks++; if (y !== 32'hFFFFFFFF || cyc != 4) begin errors++; $display("FAIL div_zero: got %0h lat %0d want ffffffff/4", y, cyc); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL div_zero_done: got %b want 00", resp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic [1:0]   rop[N];
    logic [31:0]  ra[N], rb[N];
    logic [N-1:0] exp_rdy, mask;
    logic [31:0]  exp_y;
    logic         busy, done_now;
    int           own, last_win, w, idx, completions;
    reset_dut();
    pend = '0; busy = 1'b0; own = 0; last_win = N-1; completions = 0; exp_y = '0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          rop[k]  = 2'($urandom_range(0, 3));
          ra[k]   = $urandom;
          rb[k]   = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
          drive(k, rop[k], ra[k], rb[k]);
        end
        resp_ready[k] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      exp_rdy = '0; w = -1; done_now = 1'b0;
      if (!busy) begin
        for (int i = 0; i < N; i++) begin
          idx = (last_win + 1 + i) % N;
          if (w < 0 && pend[idx]) w = idx;
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_grant c%0d: got %b want %b", c, req_ready, exp_rdy); end
      mask = busy ? (N'(1) << own) : '0;
      checks++; if ((resp_valid & ~mask) !== '0) begin errors++; $display("FAIL rand_resp_owner c%0d: got %b want within %b", c, resp_valid, mask); end
      if (busy && resp_valid[own] === 1'b1) begin
        checks++; if (resp_y !== exp_y) begin errors++; $display("FAIL rand_result c%0d: got %0h want %0h", c, resp_y, exp_y); end
        if (resp_ready[own]) done_now = 1'b1;
      end
      @(posedge clk); #1;
      if (done_now) begin
        busy = 1'b0;
        completions++;
      end
      if (w >= 0) begin
        busy         = 1'b1;
        own          = w;
        exp_y        = ref_div(rop[w], ra[w], rb[w]);
        last_win     = w;
        pend[w]      = 1'b0;
        req_valid[w] = 1'b0;
      end
    end
    checks++; if (completions < 40) begin errors++; $display("FAIL rand_progress: got %0d completions want >= 40", completions); end
    req_valid  = '0;
    resp_ready = '1;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    reset      = 1'b1;
    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_pair();
    test_div_zero();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
Shares one int_divider instance between N requesters, for example the integer pipeline and a second issue port or a microcoded sequencer. It grants one request at a time using round-robin. It drives the divider's issue and result handshakes and records which requester owns the in-flight operation. It routes the divider result back to that owner only. It sits between the requesters' execute stages and the divider; the divider itself is unchanged.

Parameters:
N, 2, number of requesters (2..8)
W, 32, operand/result width; must equal the divider's n

Ports:
clk  in  1  clock
reset  in  1  reset
req_valid  in  N  request valid per requester
req_ready  out  N  request accepted per requester
req_op  in  2*N  op per requester (UDIV/SDIV/UREM/SREM from CPU_pkg), slice k = [2k+1:2k]
req_a  in  W*N  dividend per requester, slice k
req_b  in  W*N  divisor per requester, slice k
resp_valid  out  N  result valid, only the owner's bit can be high
resp_ready  in  N  result consumed per requester
resp_y  out  W  result, shared bus, meaningful only with resp_valid
div_valid_in  out  1  to divider valid_in
div_ready_out  in  1  from divider ready_out
div_op  out  2  to divider op
div_a  out  W  to divider a
div_b  out  W  to divider b
div_valid_out  in  1  from divider valid_out
div_ready_in  out  1  to divider ready_in
div_y  in  W  from divider y

Behaviour:
- One clock, clk; reset is synchronous and active-high. The divider shares the same reset.
- Reset values: state=IDLE, owner=0, rr_ptr=0. Outputs: req_ready=0, resp_valid=0, div_valid_in=0, div_ready_in=1.
- FSM IDLE:
  - grant = first k with req_valid[k], searching from rr_ptr upward and wrapping modulo N.
  - div_valid_in = |req_valid; div_op/div_a/div_b = slice of grant (all zero when no request).
  - req_ready[grant] = div_ready_out; all other req_ready bits are 0. div_ready_in=1.
  - On fire (div_valid_in && div_ready_out): owner<=grant, rr_ptr<=(grant+1) mod N, state<=WAIT.
- FSM WAIT:
  - req_ready=0 and div_valid_in=0; no new issue.
  - resp_valid[owner] = div_valid_out; resp_y = div_y; div_ready_in = resp_ready[owner].
  - On div_valid_out && resp_ready[owner]: state<=IDLE.
- Latency: issue adds 0 cycles (combinational grant). The result appears on the cycle div_valid_out rises (4 cycles after the issue edge for W=32, divider m=8).
- After a response handshake there is one IDLE cycle before the next issue can fire. Back-to-back throughput is divider latency + 1.
- The arbiter holds the result while resp_ready[owner]=0. div_valid_out stays high and resp_y stays stable; no other requester is served.
- Requester whose req_valid drops while not granted: no effect. Requesters must keep req_valid and operands stable until req_ready.
- Simultaneous requests: exactly one fires per IDLE cycle. Losers see req_ready=0 and retry.
- rr_ptr wraps from N-1 to 0. Requesters that never assert are skipped without penalty.
- Reset mid-operation: the in-flight op is discarded with no response, resp_valid falls to 0 in the cycle after reset, and the FSM returns to IDLE.
- resp_valid bits other than the owner's are always 0. resp_y equals div_y in all states (no mux gating needed).

Optional Feature:
DIV_ARB_PAIR_EN
- Defined:
  - Arbiter keeps last_op, last_a and last_b of the completed op.
  - In the first IDLE cycle after a response, if req_valid[owner] is high and its op is the complement (UDIV<->UREM, SDIV<->SREM) with identical a and b, owner wins regardless of rr_ptr and rr_ptr is not advanced.
  - This exploits the divider's result reuse, which answers the pair without recomputing.
  - Priority applies for one cycle only.
- Undefined: strict round-robin; no operand/op history registers.

Test Plan:
- Single request: req0 UDIV a=100 b=7 -> req_ready[0] same cycle, resp_valid[0] with resp_y=14 when div_valid_out rises, resp_valid[1]=0 throughout.
- Contention: req0 and req1 both valid at reset exit (rr_ptr=0) -> req0 granted first, req1 second. Next simultaneous pair -> req0 granted first again (rr_ptr advanced past req1).
- Backpressure: req1 SREM a=-7 b=2, resp_ready[1]=0 for 5 cycles -> resp_y=-1 held stable, req_ready[0]=0 while req0 waits; req0 fires one cycle after the response handshake.
- Reset mid-operation: assert reset 2 cycles after an issue -> resp_valid=0 and state IDLE next cycle. A new UDIV 9/3 afterwards returns 3.
- Pair (DIV_ARB_PAIR_EN): req0 SDIV a=-20 b=3 -> -6; req0 SREM -20/3 and req1 UDIV valid in the same IDLE cycle with rr_ptr=1 -> req0 granted, response -2 one cycle after issue. Without the macro, req1 is granted.
- Divisor zero: req0 UDIV a=5 b=0 -> resp_y=0xFFFFFFFF passed through unchanged, handshake completes normally.
